// File: rtl/mm_pkg.sv
// Shared constants and FSM encoding for the 3x3 matrix multiplier output path.
package mm_pkg;

  localparam int N_ELEM         = 9;
  localparam int DATA_W         = 18;
  localparam int BYTES_PER_ELEM = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } ser_state_t;

endpackage

// File: rtl/result_serializer_if.sv
// Byte-wide valid/ready stream carrying serialized results to the pad driver.
interface result_serializer_if;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/result_serializer_elem_byte_mux.sv
// Selects one byte of one result element; the top byte of each element is zero-padded.
module elem_byte_mux #(
  parameter int N_ELEM         = mm_pkg::N_ELEM,
  parameter int DATA_W         = mm_pkg::DATA_W,
  parameter int BYTES_PER_ELEM = mm_pkg::BYTES_PER_ELEM,
  parameter int ELEM_W         = $clog2(N_ELEM),
  parameter int BYTE_W         = $clog2(BYTES_PER_ELEM)
) (
  input  logic [N_ELEM*DATA_W-1:0] buf_flat,
  input  logic [ELEM_W-1:0]        elem_idx,
  input  logic [BYTE_W-1:0]        byte_idx,
  output logic [7:0]               byte_out
);

  localparam int PAD_W = BYTES_PER_ELEM * 8;

  logic [DATA_W-1:0] elem_s;
  logic [PAD_W-1:0]  pad_s;

  // Element select, zero-extend to whole bytes, then byte select.
  always_comb begin
    elem_s   = {DATA_W{1'b0}};
    byte_out = 8'h00;
    if (int'(elem_idx) < N_ELEM) begin
      elem_s = buf_flat[int'(elem_idx)*DATA_W +: DATA_W];
    end else begin
      elem_s = {DATA_W{1'b0}};
    end
    pad_s = PAD_W'(elem_s);
    if (int'(byte_idx) < BYTES_PER_ELEM) begin
      byte_out = pad_s[int'(byte_idx)*8 +: 8];
    end else begin
      byte_out = 8'h00;
    end
  end

endmodule

// File: rtl/result_serializer.sv
// Captures the nine products in one cycle and streams them low byte first over
// a valid/ready byte port; done is held until the top FSM drops enable.
module result_serializer #(
  parameter int N_ELEM         = mm_pkg::N_ELEM,
  parameter int DATA_W         = mm_pkg::DATA_W,
  parameter int BYTES_PER_ELEM = mm_pkg::BYTES_PER_ELEM
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [N_ELEM*DATA_W-1:0] c_flat,
  result_serializer_if.master      out_if,
  output logic                     done
);

  import mm_pkg::*;

  localparam int ELEM_W = $clog2(N_ELEM);
  localparam int BYTE_W = $clog2(BYTES_PER_ELEM);

  ser_state_t                state_r, next_state_s;
  logic [ELEM_W-1:0]         elem_r, next_elem_s;
  logic [BYTE_W-1:0]         byte_r, next_byte_s;
  logic [N_ELEM*DATA_W-1:0]  shadow_r;
  logic [N_ELEM*DATA_W-1:0]  mux_buf_s;
  logic [7:0]                mux_byte_s;
  logic [7:0]                out_data_r;
  logic                      out_valid_r;
  logic                      done_r;

  // Next state and next indices; abort on enable low wins over a transfer.
  always_comb begin
    next_state_s = state_r;
    next_elem_s  = elem_r;
    next_byte_s  = byte_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          next_state_s = ST_SEND;
          next_elem_s  = {ELEM_W{1'b0}};
          next_byte_s  = {BYTE_W{1'b0}};
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!enable) begin
          next_state_s = ST_IDLE;
          next_elem_s  = {ELEM_W{1'b0}};
          next_byte_s  = {BYTE_W{1'b0}};
        end else if (out_if.out_ready) begin
          if (byte_r == BYTE_W'(BYTES_PER_ELEM - 1)) begin
            next_byte_s = {BYTE_W{1'b0}};
            next_elem_s = elem_r + {{(ELEM_W-1){1'b0}}, 1'b1};
            if (elem_r == ELEM_W'(N_ELEM - 1)) begin
              next_state_s = ST_DONE;
            end else begin
              next_state_s = ST_SEND;
            end
          end else begin
            next_byte_s = byte_r + {{(BYTE_W-1){1'b0}}, 1'b1};
          end
        end else begin
          next_state_s = ST_SEND;
        end
      end
      ST_DONE: begin
        if (!enable) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        next_elem_s  = {ELEM_W{1'b0}};
        next_byte_s  = {BYTE_W{1'b0}};
      end
    endcase
  end

  // The first byte is fetched straight from c_flat in the capture cycle.
  always_comb begin
    mux_buf_s = shadow_r;
    if (state_r == ST_IDLE) begin
      mux_buf_s = c_flat;
    end else begin
      mux_buf_s = shadow_r;
    end
  end

  elem_byte_mux #(
    .N_ELEM         (N_ELEM),
    .DATA_W         (DATA_W),
    .BYTES_PER_ELEM (BYTES_PER_ELEM)
  ) u_mux (
    .buf_flat (mux_buf_s),
    .elem_idx (next_elem_s),
    .byte_idx (next_byte_s),
    .byte_out (mux_byte_s)
  );

  // State, indices and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      elem_r      <= {ELEM_W{1'b0}};
      byte_r      <= {BYTE_W{1'b0}};
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      elem_r      <= next_elem_s;
      byte_r      <= next_byte_s;
      out_valid_r <= (next_state_s == ST_SEND);
      done_r      <= (next_state_s == ST_DONE);
      out_data_r  <= (next_state_s == ST_SEND) ? mux_byte_s : 8'h00;
    end
  end

  // Shadow copy of the results, loaded only on the IDLE to SEND step.
  always_ff @(posedge clk) begin
    if (rst_n && (state_r == ST_IDLE) && enable) begin
      shadow_r <= c_flat;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  assign out_if.out_data  = out_data_r;
  assign out_if.out_valid = out_valid_r;
  assign done             = done_r;

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: basic, saturated, backpressure,
// input isolation, abort and mid-stream reset.
module tb_result_serializer;

  localparam int NB = 27;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [161:0] c_flat;
  logic         done;

  result_serializer_if out_if ();

  result_serializer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .c_flat (c_flat),
    .out_if (out_if),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          fails   = 0;
  logic [17:0] c_ref [9];
  logic [7:0]  byte_log [NB];
  int          stalls;
  int          n_xfer;
  int          done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int n);
    logic [23:0] w;
    w = {6'b000000, c_ref[n / 3]};
    return w[(n % 3) * 8 +: 8];
  endfunction

  task automatic load_ref();
    for (int k = 0; k < 9; k++) c_flat[k*18 +: 18] = c_ref[k];
  endtask

  // Called just after a rising edge with enable already driven high.
  task automatic run_stream(input bit random_ready, input int stop_after, input bit scramble);
    bit         stalled;
    logic [7:0] held;
    logic       rdy;
    stalled  = 1'b0;
    held     = 8'h00;
    n_xfer   = 0;
    done_cyc = 0;
    stalls   = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      if (scramble) c_flat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (done) begin
        done_cyc = cyc;
        check("done_valid_low", {31'd0, out_if.out_valid}, 32'd0);
        break;
      end
      check("valid_while_streaming", {31'd0, out_if.out_valid}, 32'd1);
      if (stalled) check("stall_hold", {24'd0, out_if.out_data}, {24'd0, held});
      rdy = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      out_if.out_ready = rdy;
      if (out_if.out_valid && rdy) begin
        if (n_xfer < NB) begin
          check($sformatf("byte%0d", n_xfer), {24'd0, out_if.out_data}, {24'd0, exp_byte(n_xfer)});
          byte_log[n_xfer] = out_if.out_data;
        end
        n_xfer++;
        stalled = 1'b0;
        if (n_xfer == stop_after && stop_after < NB) break;
      end else begin
        stalls++;
        stalled = 1'b1;
        held    = out_if.out_data;
      end
    end
    if (stop_after >= NB) begin
      check("xfer_count", n_xfer, NB);
      check("done_cycle", done_cyc, 28 + stalls);
    end
  endtask

  // Hold enable in DONE, then drop it and confirm return to idle.
  task automatic finish_done();
    repeat (2) begin
      @(posedge clk); #1;
      check("done_level", {31'd0, done}, 32'd1);
    end
    enable = 1'b0;
    @(posedge clk); #1;
    check("done_clear", {31'd0, done}, 32'd0);
    check("idle_valid", {31'd0, out_if.out_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    c_flat = '0;
    out_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_if.out_valid}, 32'd0);
    check("rst_data", {24'd0, out_if.out_data}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    // Basic stream
    c_ref[0] = 18'h2ABCD;
    for (int k = 1; k < 9; k++) c_ref[k] = 18'(k);
    load_ref();
    out_if.out_ready = 1'b1;
    enable = 1'b1;
    run_stream(1'b0, NB, 1'b0);
    check("basic_b0", {24'd0, byte_log[0]}, 32'hCD);
    check("basic_b1", {24'd0, byte_log[1]}, 32'hAB);
    check("basic_b2", {24'd0, byte_log[2]}, 32'h02);
    check("basic_b3", {24'd0, byte_log[3]}, 32'h01);
    check("basic_b24", {24'd0, byte_log[24]}, 32'h08);
    check("basic_done_cyc", done_cyc, 28);
    finish_done();

    // Saturated top element
    c_ref[8] = 18'h3FFFF;
    load_ref();
    enable = 1'b1;
    run_stream(1'b0, NB, 1'b0);
    check("sat_b24", {24'd0, byte_log[24]}, 32'hFF);
    check("sat_b25", {24'd0, byte_log[25]}, 32'hFF);
    check("sat_b26", {24'd0, byte_log[26]}, 32'h03);
    finish_done();

    // Backpressure
    for (int k = 0; k < 9; k++) c_ref[k] = 18'(k * 18'h1357 + 18'h00A5);
    load_ref();
    enable = 1'b1;
    run_stream(1'b1, NB, 1'b0);
    out_if.out_ready = 1'b1;
    finish_done();

    // Input isolation
    for (int k = 0; k < 9; k++) c_ref[k] = 18'h3C000 ^ 18'(k * 18'h0421);
    load_ref();
    enable = 1'b1;
    run_stream(1'b0, NB, 1'b1);
    finish_done();

    // Abort after 5 transfers, then restart with fresh data
    for (int k = 0; k < 9; k++) c_ref[k] = 18'(18'h11111 + k);
    load_ref();
    enable = 1'b1;
    run_stream(1'b0, 5, 1'b0);
    enable = 1'b0;
    @(posedge clk); #1;
    check("abort_valid", {31'd0, out_if.out_valid}, 32'd0);
    check("abort_data", {24'd0, out_if.out_data}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    for (int k = 0; k < 9; k++) c_ref[k] = 18'(18'h20F00 + k * 18'h33);
    load_ref();
    enable = 1'b1;
    run_stream(1'b0, NB, 1'b0);
    check("restart_b0", {24'd0, byte_log[0]}, 32'h00);
    check("restart_b1", {24'd0, byte_log[1]}, 32'h0F);
    finish_done();

    // Reset at transfer 13
    for (int k = 0; k < 9; k++) c_ref[k] = 18'(18'h0A0A0 + k * 18'h101);
    load_ref();
    enable = 1'b1;
    run_stream(1'b0, 13, 1'b0);
    rst_n  = 1'b0;
    enable = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", {31'd0, out_if.out_valid}, 32'd0);
    check("midrst_data", {24'd0, out_if.out_data}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) c_ref[k] = 18'(18'h15555 - k);
    load_ref();
    enable = 1'b1;
    run_stream(1'b0, NB, 1'b0);
    finish_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/result_serializer.md
# result_serializer

Output stage of the 3×3 matrix multiplier. Captures the nine 18-bit products from the compute stage in one cycle and streams them out as 27 bytes over an 8-bit valid/ready port. It drives the chip's `uo_out`/`uio_out[0]` path and reports completion to the top-level FSM.

## Interface

Parameters:
- `N_ELEM`, default 9: number of result elements.
- `DATA_W`, default 18: width of each result element.
- `BYTES_PER_ELEM`, default 3: equals ceil(`DATA_W`/8).

Ports (one clock; reset is synchronous and active-low):
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: synchronous active-low reset.
- `enable`, in, 1: top FSM in OUTPUT state.
- `c_flat`, in, `N_ELEM*DATA_W` (162): results; element k is `c_flat[k*DATA_W +: DATA_W]`.
- `out_ready`, in, 1: consumer accepts the current byte.
- `out_data`, out, 8: current byte.
- `out_valid`, out, 1: `out_data` is valid.
- `done`, out, 1: all bytes accepted.

## Operation

- States: IDLE, SEND, DONE.
- IDLE:
  - If `enable`=1, register all of `c_flat` into a shadow buffer, clear `elem_idx` and `byte_idx`, and go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - `out_valid`=1.
  - `out_data` is byte `byte_idx` of shadow element `elem_idx`:
    - byte 0 = bits [7:0]
    - byte 1 = bits [15:8]
    - byte 2 = {6'b0, bits[17:16]} (the upper bits are zero-filled)
  - Order: element 0 first, low byte first.
  - Transfer occurs when `out_valid & out_ready`. On transfer:
    - If `byte_idx` < 2, increment `byte_idx`.
    - Otherwise set `byte_idx` to 0 and increment `elem_idx`.
  - A transfer on the last byte (`elem_idx`=8, `byte_idx`=2) goes to DONE.
  - While `out_ready`=0, `out_data` and both indices hold stable.
  - If `enable` drops during SEND: abort to IDLE. `out_valid`=0 next cycle; `done` is not asserted. An abort takes priority over a simultaneous transfer.
- DONE:
  - `done`=1, `out_valid`=0.
  - Remain in DONE while `enable`=1. Return to IDLE when `enable`=0.
- Shadow buffer:
  - Written only in the IDLE→SEND cycle.
  - Later changes on `c_flat` do not affect the stream.
- Reset values: state IDLE, indices 0, `out_data`=8'h00, `out_valid`=0, `done`=0. The shadow buffer is not reset.
- `rst_n`=0 in any state, including mid-stream, returns to reset values at the next edge.
- `out_data` is 8'h00 whenever `out_valid`=0.

## Timing

- All outputs are registered or decoded from registered state. There is no combinational path from `out_ready` to `out_valid`.
- Cycle 0: `enable` is sampled high in IDLE.
- Cycle 1: `out_valid`=1 and byte 0 of element 0 is presented.
- With `out_ready` held high, one byte transfers per cycle. The last byte is at cycle 27 and `done`=1 from cycle 28.
- Each cycle with `out_ready`=0 during SEND adds one cycle of latency.
- `done` is a level, not a pulse. It remains high until `enable` falls or reset.

## Structure

- Shared package `mm_pkg` holds `N_ELEM`, `DATA_W`, `BYTES_PER_ELEM` and the state encoding (IDLE=2'd0, SEND=2'd1, DONE=2'd2).
- One sub-module, `elem_byte_mux`, is combinational. It takes the shadow buffer, `elem_idx` and `byte_idx`, and returns the 8-bit byte.
- FSM, counters and shadow register stay in `result_serializer`.

## Test plan

- Basic stream: C[0]=18'h2ABCD, C[k]=k for k=1..8, `out_ready`=1 → bytes CD,AB,02, then 01,00,00, … , 08,00,00. `done`=1 at cycle 28.
- Saturated top bits: C[8]=18'h3FFFF → last three bytes are FF,FF,03. `done` asserts only after the 03 byte is accepted.
- Backpressure: toggle `out_ready` pseudo-randomly → `out_data` stays stable during stalls and no byte is duplicated or dropped. There are exactly 27 transfers.
- Input isolation: change `c_flat` every cycle after capture → the stream matches the values captured at cycle 0.
- Abort: drop `enable` after 5 transfers → `out_valid`=0 next cycle and `done` stays 0. Re-raise `enable` → the stream restarts at element 0, byte 0, with newly captured data.
- Reset mid-stream: `rst_n`=0 for 1 cycle at transfer 13 → all outputs are 0 the next cycle. A new `enable` produces a full 27-byte stream.
